// File: rtl/emotion_pkg.sv
// Shared constants and types for the emotion tracker: one-hot bit positions,
// physical_state encodings and the hysteresis FSM state type.
package emotion_pkg;

  localparam int EMO_W        = 8;

  localparam int EMO_SLEEPY   = 0;
  localparam int EMO_BORED    = 1;
  localparam int EMO_CALM     = 2;
  localparam int EMO_HAPPY    = 3;
  localparam int EMO_EXCITED  = 4;
  localparam int EMO_STRESSED = 5;
  localparam int EMO_ANGRY    = 6;
  localparam int EMO_SAD      = 7;

  localparam logic [1:0] PHYS_AWAKE  = 2'd0;
  localparam logic [1:0] PHYS_HUNGRY = 2'd1;
  localparam logic [1:0] PHYS_TIRED  = 2'd2;
  localparam logic [1:0] PHYS_ASLEEP = 2'd3;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } trk_state_e;

endpackage

// File: rtl/emotion_classifier.sv
// Combinational classifier: quantises each drive level to its top two bits and
// applies the priority rules to produce a one-hot candidate emotion.
module emotion_classifier
  import emotion_pkg::*;
#(
  parameter int LEVEL_W = 2
) (
  input  logic [LEVEL_W-1:0] energy_i,
  input  logic [LEVEL_W-1:0] stress_i,
  input  logic [LEVEL_W-1:0] pleasure_i,
  input  logic [1:0]         phys_i,
  output logic [EMO_W-1:0]   cand_o
);

  logic [1:0] eq, sq, pq;
  logic [2:0] idx;

  // Shifting then truncating keeps every input bit referenced for any LEVEL_W.
  assign eq = 2'(energy_i   >> (LEVEL_W - 2));
  assign sq = 2'(stress_i   >> (LEVEL_W - 2));
  assign pq = 2'(pleasure_i >> (LEVEL_W - 2));

  always_comb begin
    idx = 3'(EMO_CALM);
    if (phys_i == PHYS_ASLEEP)        idx = 3'(EMO_SLEEPY);
    else if (sq == 2'd3 && eq >= 2'd2) idx = 3'(EMO_ANGRY);
    else if (sq >= 2'd2)               idx = 3'(EMO_STRESSED);
    else if (pq == 2'd0)               idx = 3'(EMO_SAD);
    else if (eq == 2'd0)               idx = 3'(EMO_SLEEPY);
    else if (pq == 2'd3 && eq == 2'd3) idx = 3'(EMO_EXCITED);
    else if (pq >= 2'd2)               idx = 3'(EMO_HAPPY);
    else if (eq == 2'd1)               idx = 3'(EMO_BORED);
  end

  assign cand_o = EMO_W'(1) << idx;

endmodule

// File: rtl/emotion_tracker.sv
// Tick-driven hysteresis around the classifier: a new emotion commits only after
// HOLD_TICKS consecutive identical candidates; reports change pulse and dwell.
module emotion_tracker
  import emotion_pkg::*;
#(
  parameter int LEVEL_W    = 2,
  parameter int HOLD_TICKS = 4,
  parameter int DWELL_W    = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               tick_i,
  input  logic [LEVEL_W-1:0] energy_i,
  input  logic [LEVEL_W-1:0] stress_i,
  input  logic [LEVEL_W-1:0] pleasure_i,
  input  logic [1:0]         physical_state_i,
  output logic [EMO_W-1:0]   emotion_o,
  output logic               emotion_changed_o,
  output logic               emotion_pending_o,
  output logic [DWELL_W-1:0] dwell_o
);

  localparam int CNT_W = $clog2(HOLD_TICKS + 1);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_TICKS);
  localparam logic [EMO_W-1:0] CALM_OH = EMO_W'(1) << EMO_CALM;

  trk_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_nxt;
  logic [EMO_W-1:0]   pend_q, pend_d;
  logic [EMO_W-1:0]   emo_q, emo_d;
  logic               chg_q, chg_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d, dwell_inc;
  logic [EMO_W-1:0]   cand;

  emotion_classifier #(.LEVEL_W(LEVEL_W)) u_classifier (
    .energy_i   (energy_i),
    .stress_i   (stress_i),
    .pleasure_i (pleasure_i),
    .phys_i     (physical_state_i),
    .cand_o     (cand)
  );

  assign dwell_inc = (dwell_q == '1) ? dwell_q : dwell_q + DWELL_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    emo_d   = emo_q;
    chg_d   = 1'b0;
    dwell_d = dwell_q;
    cnt_nxt = CNT_W'(1);
    if (tick_i) begin
      if (cand == emo_q) begin
        state_d = ST_STABLE;
        cnt_d   = '0;
        dwell_d = dwell_inc;
      end else begin
        // A different candidate than the one being qualified restarts the count.
        if (state_q == ST_PENDING && cand == pend_q) cnt_nxt = cnt_q + CNT_W'(1);
        pend_d = cand;
        if (cnt_nxt == HOLD_C) begin
          emo_d   = cand;
          chg_d   = 1'b1;
          dwell_d = '0;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          state_d = ST_PENDING;
          cnt_d   = cnt_nxt;
          dwell_d = dwell_inc;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      pend_q  <= CALM_OH;
      emo_q   <= CALM_OH;
      chg_q   <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      emo_q   <= emo_d;
      chg_q   <= chg_d;
      dwell_q <= dwell_d;
    end
  end

  assign emotion_o         = emo_q;
  assign emotion_changed_o = chg_q;
  assign emotion_pending_o = (state_q == ST_PENDING);
  assign dwell_o           = dwell_q;

endmodule
